// File: rtl/div_hilo_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer:
// state encoding, watchdog default and the divide-by-zero LO value.
package div_hilo_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BUSY  = 3'd1;
  localparam logic [2:0] ST_ZERO  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  localparam int TIMEOUT_DEF = 40;

  localparam logic [31:0] ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_BUSY  = ST_BUSY,
    S_ZERO  = ST_ZERO,
    S_DONE  = ST_DONE,
    S_ABORT = ST_ABORT
  } state_t;

endpackage

// File: rtl/div_hilo_ctrl_if.sv
// Bundle between the EX stage, the iterative divider and the HI/LO owner.
// master: the sequencer. slave: pipeline + divider side.
interface div_hilo_ctrl_if;

  logic        ex_div_valid;
  logic        ex_div_signed;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        ex_flush;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_wdata;
  logic        stall_req;
  logic        div_begin;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [31:0] div_result;
  logic [31:0] div_remainder;
  logic        div_end;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;

  modport master (
    input  ex_div_valid, ex_div_signed,
    input  ex_op1, ex_op2, ex_flush,
    input  mthi_we, mtlo_we, mt_wdata,
    input  div_result, div_remainder, div_end,
    output stall_req, div_begin, div_signed,
    output div_op1, div_op2,
    output hi, lo, timeout_err
  );

  modport slave (
    output ex_div_valid, ex_div_signed,
    output ex_op1, ex_op2, ex_flush,
    output mthi_we, mtlo_we, mt_wdata,
    output div_result, div_remainder, div_end,
    input  stall_req, div_begin, div_signed,
    input  div_op1, div_op2,
    input  hi, lo, timeout_err
  );

endinterface

// File: rtl/div_hilo_ctrl.sv
// DIV/DIVU sequencer: latches operands, runs the divider, stalls EX,
// owns HI/LO (also MTHI/MTLO), aborts on flush and on a watchdog timeout.
// Ports: clk, rst (sync, active-high), bus (div_hilo_ctrl_if.master).
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  div_hilo_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] W_TMO    = CW'(TIMEOUT);
  localparam logic [CW-1:0] W_TMO_M1 = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_op1;
  logic [31:0]   r_op2;
  logic          r_signed;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [CW-1:0] r_cnt;
  logic          r_tmo;

  logic w_req;
  logic w_zero;
  logic w_div_wr;
  logic w_tmo;

  assign w_req  = bus.ex_div_valid & ~bus.ex_flush;
  assign w_zero = (bus.ex_op2 == 32'd0);

  always_comb begin
    w_next   = r_state;
    w_div_wr = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req)
          w_next = w_zero ? S_ZERO : S_BUSY;
      end
      S_BUSY: begin
        // flush outranks a same-cycle div_end
        if (bus.ex_flush) begin
          w_next = S_ABORT;
        end else if (bus.div_end) begin
          w_next   = S_DONE;
          w_div_wr = 1'b1;
        end else if (r_cnt == W_TMO_M1) begin
          w_next = S_ABORT;
          w_tmo  = 1'b1;
        end
      end
      S_ZERO:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op1    <= '0;
      r_op2    <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE && w_req) begin
        r_op1 <= bus.ex_op1;
        if (!w_zero) begin
          r_op2    <= bus.ex_op2;
          r_signed <= bus.ex_div_signed;
        end
      end

      if (r_state != S_BUSY && w_next == S_BUSY)
        r_cnt <= '0;
      else if (r_state == S_BUSY && r_cnt != W_TMO)
        r_cnt <= r_cnt + CW'(1);

      if (w_tmo)
        r_tmo <= 1'b1;

      // division result beats an MTHI/MTLO on the same edge
      if (w_div_wr)
        r_hi <= bus.div_remainder;
      else if (r_state == S_ZERO)
        r_hi <= r_op1;
      else if (bus.mthi_we)
        r_hi <= bus.mt_wdata;

      if (w_div_wr)
        r_lo <= bus.div_result;
      else if (r_state == S_ZERO)
        r_lo <= ZERO_LO;
      else if (bus.mtlo_we)
        r_lo <= bus.mt_wdata;
    end
  end

  assign bus.div_begin   = (r_state == S_BUSY);
  assign bus.stall_req   = ((r_state == S_IDLE) & w_req)
                         | (r_state == S_BUSY)
                         | (r_state == S_ZERO);
  assign bus.div_signed  = r_signed;
  assign bus.div_op1     = r_op1;
  assign bus.div_op2     = r_op2;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.timeout_err = r_tmo;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl with a behavioural divider stub
// of programmable latency; HI/LO expectations via scoreboard queue.
module tb_div_hilo_ctrl;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  int stub_lat = 34;
  bit stub_en = 1'b1;
  int stub_cnt = 0;

  div_hilo_ctrl_if bus();

  div_hilo_ctrl #(.TIMEOUT(40)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // divider stub: div_end pulses in the stub_lat-th busy cycle
  always @(posedge clk) begin
    if (rst || !bus.div_begin) begin
      stub_cnt    <= 0;
      bus.div_end <= 1'b0;
    end else begin
      stub_cnt    <= stub_cnt + 1;
      bus.div_end <= stub_en && (stub_cnt == stub_lat - 2);
    end
  end

  always_comb begin
    bus.div_result    = '0;
    bus.div_remainder = '0;
    if (bus.div_op2 != 32'd0) begin
      if (bus.div_signed) begin
        bus.div_result    = $signed(bus.div_op1) / $signed(bus.div_op2);
        bus.div_remainder = $signed(bus.div_op1) % $signed(bus.div_op2);
      end else begin
        bus.div_result    = bus.div_op1 / bus.div_op2;
        bus.div_remainder = bus.div_op1 % bus.div_op2;
      end
    end
  end

  task automatic run_div(
    input logic        sgn,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ehi,
    input logic [31:0] elo,
    input int          exp_stall,
    input bit          exp_begin,
    input bit          mt_on_end,
    input string       name
  );
    int   n;
    bit   saw;
    exp_t e;
    n   = 0;
    saw = 1'b0;
    sb_q.push_back('{hi: ehi, lo: elo});
    @(negedge clk);
    bus.ex_div_valid  = 1'b1;
    bus.ex_div_signed = sgn;
    bus.ex_op1        = a;
    bus.ex_op2        = b;
    #1;
    while (bus.stall_req && n < 200) begin
      n++;
      if (bus.div_begin) saw = 1'b1;
      @(negedge clk);
      // operands must have been captured already
      bus.ex_op1   = ~a;
      bus.ex_op2   = b ^ 32'h5A5A_0000;
      bus.mthi_we  = mt_on_end && bus.div_end;
      bus.mt_wdata = 32'hDEAD_BEEF;
      #1;
    end
    tests_run++;
    if (n !== exp_stall) begin
      tests_failed++;
      $display("FAIL %s stall_cycles got %0d want %0d",
               name, n, exp_stall);
    end
    tests_run++;
    if (saw !== exp_begin) begin
      tests_failed++;
      $display("FAIL %s div_begin_seen got %0b want %0b",
               name, saw, exp_begin);
    end
    tests_run++;
    if (bus.div_begin !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_div_begin got %0b want 0",
               name, bus.div_begin);
    end
    e = sb_q.pop_front();
    tests_run++;
    if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      tests_failed++;
      $display("FAIL %s hi/lo got %h/%h want %h/%h",
               name, bus.hi, bus.lo, e.hi, e.lo);
    end
    bus.ex_div_valid = 1'b0;
    bus.mthi_we      = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.stall_req !== 1'b0 || bus.div_begin !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle stall/begin got %0b/%0b want 0/0",
               name, bus.stall_req, bus.div_begin);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset hi/lo got %h/%h want 0/0", bus.hi, bus.lo);
    end
    tests_run++;
    if ({bus.div_op1, bus.div_op2, bus.div_signed} !== 65'd0) begin
      tests_failed++;
      $display("FAIL reset div_ops got %h/%h/%0b want 0",
               bus.div_op1, bus.div_op2, bus.div_signed);
    end
    tests_run++;
    if ({bus.div_begin, bus.stall_req, bus.timeout_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset ctrl got %b want 000",
               {bus.div_begin, bus.stall_req, bus.timeout_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_divu();
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35, 1'b1, 1'b0,
            "divu_100_7");
    run_div(1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 35,
            1'b1, 1'b0, "divu_min_1");
  endtask

  task automatic test_div_signed();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
            35, 1'b1, 1'b0, "div_m7_2");
  endtask

  task automatic test_div_zero();
    run_div(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 1'b0, 1'b0,
            "div_5_0");
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.ex_div_valid = 1'b1;
    bus.ex_flush     = 1'b1;
    bus.ex_op1       = 32'd40;
    bus.ex_op2       = 32'd4;
    #1;
    tests_run++;
    if (bus.stall_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle stall got %0b want 0", bus.stall_req);
    end
    @(negedge clk);
    bus.ex_div_valid = 1'b0;
    bus.ex_flush     = 1'b0;
    #1;
    tests_run++;
    if (bus.div_begin !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle div_begin got %0b want 0",
               bus.div_begin);
    end
    // divider completes in the same cycle as the flush
    stub_lat = 10;
    @(negedge clk);
    bus.ex_div_valid  = 1'b1;
    bus.ex_div_signed = 1'b0;
    bus.ex_op1        = 32'd1000;
    bus.ex_op2        = 32'd10;
    repeat (10) @(negedge clk);
    bus.ex_flush     = 1'b1;
    bus.ex_div_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.stall_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_busy stall got %0b want 1", bus.stall_req);
    end
    @(negedge clk);
    bus.ex_flush = 1'b0;
    #1;
    tests_run++;
    if (bus.div_begin !== 1'b0 || bus.stall_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_abort begin/stall got %0b/%0b want 0/0",
               bus.div_begin, bus.stall_req);
    end
    tests_run++;
    if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL flush_nowrite hi/lo got %h/%h want %h/%h",
               bus.hi, bus.lo, 32'd5, 32'hFFFF_FFFF);
    end
    stub_lat = 34;
    run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 35, 1'b1, 1'b0,
            "divu_9_3");
  endtask

  task automatic test_mt();
    @(negedge clk);
    bus.mthi_we  = 1'b1;
    bus.mt_wdata = 32'h1234;
    @(negedge clk);
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b1;
    bus.mt_wdata = 32'h5678;
    #1;
    tests_run++;
    if (bus.hi !== 32'h1234) begin
      tests_failed++;
      $display("FAIL mthi got %h want %h", bus.hi, 32'h1234);
    end
    @(negedge clk);
    bus.mtlo_we = 1'b0;
    #1;
    tests_run++;
    if (bus.lo !== 32'h5678) begin
      tests_failed++;
      $display("FAIL mtlo got %h want %h", bus.lo, 32'h5678);
    end
    run_div(1'b0, 32'd8, 32'd3, 32'd2, 32'd2, 35, 1'b1, 1'b1,
            "divu_8_3_mthi");
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    stub_en = 1'b0;
    @(negedge clk);
    bus.ex_div_valid  = 1'b1;
    bus.ex_div_signed = 1'b0;
    bus.ex_op1        = 32'd50;
    bus.ex_op2        = 32'd5;
    #1;
    while (bus.stall_req && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    bus.ex_div_valid = 1'b0;
    tests_run++;
    if (n !== 41) begin
      tests_failed++;
      $display("FAIL timeout stall_cycles got %0d want 41", n);
    end
    tests_run++;
    if (bus.timeout_err !== 1'b1 || bus.div_begin !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout err/begin got %0b/%0b want 1/0",
               bus.timeout_err, bus.div_begin);
    end
    tests_run++;
    if (bus.hi !== 32'd2 || bus.lo !== 32'd2) begin
      tests_failed++;
      $display("FAIL timeout_nowrite hi/lo got %h/%h want 2/2",
               bus.hi, bus.lo);
    end
    stub_en = 1'b1;
    run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 35,
            1'b1, 1'b0, "div_100_m7");
    tests_run++;
    if (bus.timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky got %0b want 1", bus.timeout_err);
    end
  endtask

  task automatic test_rst_mid_busy();
    stub_en = 1'b0;
    @(negedge clk);
    bus.ex_div_valid  = 1'b1;
    bus.ex_div_signed = 1'b1;
    bus.ex_op1        = 32'd77;
    bus.ex_op2        = 32'd7;
    repeat (5) @(negedge clk);
    rst              = 1'b1;
    bus.ex_div_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_busy hi/lo got %h/%h want 0/0", bus.hi, bus.lo);
    end
    tests_run++;
    if ({bus.div_op1, bus.div_op2, bus.div_signed} !== 65'd0) begin
      tests_failed++;
      $display("FAIL rst_busy div_ops got %h/%h/%0b want 0",
               bus.div_op1, bus.div_op2, bus.div_signed);
    end
    tests_run++;
    if ({bus.div_begin, bus.stall_req, bus.timeout_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_busy ctrl got %b want 000",
               {bus.div_begin, bus.stall_req, bus.timeout_err});
    end
    stub_en = 1'b1;
    run_div(1'b0, 32'd77, 32'd7, 32'd0, 32'd11, 35, 1'b1, 1'b0,
            "divu_77_7");
  endtask

  initial begin
    bus.ex_div_valid  = 1'b0;
    bus.ex_div_signed = 1'b0;
    bus.ex_op1        = '0;
    bus.ex_op2        = '0;
    bus.ex_flush      = 1'b0;
    bus.mthi_we       = 1'b0;
    bus.mtlo_we       = 1'b0;
    bus.mt_wdata      = '0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_flush();
    test_mt();
    test_timeout();
    test_rst_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
